scope_tap_capture: RTL and testbench
====================================

Name: scope_tap_capture

Overview:
Downstream consumer of the core CSR data-tap bundle. It samples the four 1-bit tap flags and the 32-bit tap word on every cycle where the tapped gated-clock indicator is high. Captures run into a circular trace buffer with programmable trigger and post-trigger depth. Once a capture completes, the stored samples are drained oldest-first through a valid/ready read port to the scope readout logic.

Parameters:
DEPTH, 16, trace buffer entries; power of two, >= 4
AW, log2(DEPTH), buffer pointer width (derived, not overridden)

Ports:
clock  input  1  single block clock
reset  input  1  synchronous, active-high reset
tap_flags  input  4  tapped 1-bit CSR/core signals, bit3..bit0
tap_data  input  32  tapped 32-bit CSR value
tap_clk_en  input  1  tapped gated-clock output; sample only when 1
arm  input  1  level; 1 = capture enabled, 0 = abort/idle
trig_mask  input  4  per-flag trigger compare enable
trig_value  input  4  per-flag trigger compare value
post_count  input  AW  samples to capture after the trigger sample; clamped to DEPTH-1
rd_valid  output  1  read entry available
rd_ready  input  1  consumer accepts entry
rd_data  output  36  {tap_flags, tap_data} of oldest unread sample
state  output  2  0 IDLE, 1 PRE, 2 POST, 3 DONE
triggered  output  1  sticky; trigger seen in the current capture
overflow  output  1  sticky; pre-trigger samples were overwritten

Behaviour:
- Reset: state=IDLE, wr_ptr=0, rd_ptr=0, fill=0, post_left=0, triggered=0, overflow=0, rd_valid=0, rd_data=0. Buffer contents are don't-care.
- sample = tap_clk_en in PRE or POST. No sampling in IDLE or DONE.
- hit = sample & (((tap_flags ^ trig_value) & trig_mask) == 0). trig_mask=0 fires on the first sample.
- IDLE:
  - arm=1 -> PRE next cycle.
  - Entering PRE clears wr_ptr, fill, triggered and overflow.
- PRE:
  - Each sample is written at wr_ptr; wr_ptr+1 wraps mod DEPTH; fill saturates at DEPTH.
  - A write while fill==DEPTH sets overflow.
  - On hit: the sample is written, triggered=1, post_left=min(post_count, DEPTH-1).
  - Next state is POST, or DONE if post_left==0.
- POST:
  - Each sample is written and decrements post_left.
  - The sample that makes post_left reach 0 -> DONE next cycle.
  - Overwrites in POST do not set overflow. The clamp guarantees the trigger sample survives.
- DONE:
  - On entry, rd_ptr = wr_ptr - fill (mod DEPTH), so the drain starts from the oldest sample.
  - rd_valid = (fill != 0); rd_data = buf[rd_ptr], driven combinationally from the flop array.
  - A pop (rd_valid & rd_ready) advances rd_ptr and decrements fill.
  - The pop that takes fill to 0 -> IDLE next cycle. triggered and overflow hold until the next arm.
  - rd_data is stable while rd_valid=1 and rd_ready=0.
- arm=0 in PRE or POST -> IDLE next cycle, fill=0, no readout (abort). arm has no effect in DONE; the drain always completes.
- Config inputs (trig_*, post_count) are sampled per cycle in PRE and must be held stable by software while armed. post_count is latched at the trigger.
- No write and read occur in the same cycle; the states are exclusive.
- Reset asserted mid-capture or mid-drain returns every output to its reset value in the next cycle.
- Latency: hit sample to state=POST/DONE is 1 cycle. DONE entry to rd_valid=1 is 0 cycles. Last pop to state=IDLE is 1 cycle.

Test Plan:
- DEPTH=16, mask=0, post_count=3, tap_clk_en=1, tap_data=0x100+n -> 4 samples 0x100..0x103 drained in order; triggered=1, overflow=0, state back to IDLE after the 4th pop.
- mask=4'b0001, value=1, flag0 rises on sample 20, post_count=5 -> 16 entries drained, first = sample 10, last = sample 25; overflow=1.
- tap_clk_en toggles every other cycle -> only enabled cycles are stored; entry count equals the number of enabled cycles in the capture window.
- post_count=15 (max) with trigger on sample 0 -> 16 entries drained, trigger sample first; post_count=0 -> a single entry, and DONE is reached the cycle after the hit.
- rd_ready held low for 5 cycles in DONE -> rd_valid=1 and rd_data unchanged throughout; arm toggled low during DONE -> drain still completes.
- arm dropped in POST, and separately reset pulsed in DONE with fill=7 -> IDLE next cycle, rd_valid=0, and for reset triggered=0, overflow=0.

Source files
------------

// File: rtl/scope_tap_capture_if.sv
// rtl/scope_tap_capture_if.sv - trace readout valid/ready port
interface scope_tap_capture_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [35:0] rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/scope_tap_capture.sv
// rtl/scope_tap_capture.sv - CSR data-tap trace capture with trigger and drain
module scope_tap_capture #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          tap_flags,
    input  logic [31:0]         tap_data,
    input  logic                tap_clk_en,
    input  logic                arm,
    input  logic [3:0]          trig_mask,
    input  logic [3:0]          trig_value,
    input  logic [AW-1:0]       post_count,
    scope_tap_capture_if.master rd,
    output logic [1:0]          state,
    output logic                triggered,
    output logic                overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        POST = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    state_t        st;
    state_t        st_n;
    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] post_left;
    logic [AW:0]   fill;

    logic          sample;
    logic          wr_en;
    logic          hit;
    logic          pop;
    logic          last_post;
    logic          enter_done;
    logic [AW:0]   fill_wr;
    logic [AW-1:0] wr_next;
    logic [AW-1:0] rd_start;

    assign sample     = tap_clk_en && (st == PRE || st == POST);
    assign wr_en      = sample && arm;
    assign hit        = sample && (st == PRE) && (((tap_flags ^ trig_value) & trig_mask) == 4'b0000);
    assign pop        = rd.rd_valid && rd.rd_ready;
    assign last_post  = wr_en && (st == POST) && (post_left == ONE);
    // post_count is AW bits wide, so it can never exceed DEPTH-1; the clamp is implicit.
    assign enter_done = (wr_en && hit && (post_count == '0)) || last_post;
    assign fill_wr    = (fill == FULL) ? fill : fill + FILL_ONE;
    assign wr_next    = wr_ptr + ONE;
    // Oldest surviving sample, computed from the post-write pointer and fill.
    assign rd_start   = wr_next - fill_wr[AW-1:0];

    assign rd.rd_valid = (st == DONE) && (fill != '0);
    assign rd.rd_data  = rd.rd_valid ? mem[rd_ptr] : 36'd0;
    assign state       = st;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) st <= IDLE;
        else       st <= st_n;
    end

    // Next-state selection: arm aborts a capture but never a drain.
    always_comb begin
        st_n = st;
        case (st)
            IDLE: if (arm) st_n = PRE;
            PRE: begin
                if (!arm)    st_n = IDLE;
                else if (hit) st_n = (post_count == '0) ? DONE : POST;
            end
            POST: begin
                if (!arm)          st_n = IDLE;
                else if (last_post) st_n = DONE;
            end
            DONE: if (fill == '0 || (pop && fill == FILL_ONE)) st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    // Pointer, fill, post-trigger countdown and sticky status bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            post_left <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (arm) begin
                        wr_ptr    <= '0;
                        fill      <= '0;
                        triggered <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
                PRE: begin
                    if (!arm) begin
                        fill <= '0;
                    end else if (sample) begin
                        wr_ptr <= wr_next;
                        fill   <= fill_wr;
                        if (fill == FULL) overflow <= 1'b1;
                        if (hit) begin
                            triggered <= 1'b1;
                            post_left <= post_count;
                        end
                        if (enter_done) rd_ptr <= rd_start;
                    end
                end
                POST: begin
                    if (!arm) begin
                        fill <= '0;
                    end else if (sample) begin
                        wr_ptr    <= wr_next;
                        fill      <= fill_wr;
                        post_left <= post_left - ONE;
                        if (enter_done) rd_ptr <= rd_start;
                    end
                end
                DONE: begin
                    if (pop) begin
                        rd_ptr <= rd_ptr + ONE;
                        fill   <= fill - FILL_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Trace storage; contents need no reset.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= {tap_flags, tap_data};
    end

endmodule

// File: tb/tb_scope_tap_capture.sv
// tb/tb_scope_tap_capture.sv - scoreboard bench for scope_tap_capture
module tb_scope_tap_capture;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  tap_flags;
    logic [31:0] tap_data;
    logic        tap_clk_en;
    logic        arm;
    logic [3:0]  trig_mask;
    logic [3:0]  trig_value;
    logic [3:0]  post_count;
    logic [1:0]  state;
    logic        triggered;
    logic        overflow;

    scope_tap_capture_if rd_if ();

    scope_tap_capture #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .tap_flags  (tap_flags),
        .tap_data   (tap_data),
        .tap_clk_en (tap_clk_en),
        .arm        (arm),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .post_count (post_count),
        .rd         (rd_if),
        .state      (state),
        .triggered  (triggered),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_err = 0;
    logic [35:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one capture and models the expected surviving trace in a queue.
    task automatic run_capture(input logic [3:0] mask, input logic [3:0] val, input int trig_at,
                               input int post, input bit alt_en, input bit abort_in_post);
        logic [35:0] hist [$];
        bit          in_post = 0;
        bit          fin = 0;
        bit          movf = 0;
        bit          hit_now;
        int          left = 0;
        int          k = 0;
        logic [3:0]  fl;
        trig_mask  = mask;
        trig_value = val;
        post_count = post[3:0];
        arm        = 1'b1;
        tick();
        check("arm_to_pre", state, 1);
        while (!fin && k < 200) begin
            fl         = (k >= trig_at) ? val : ~val;
            tap_flags  = fl;
            tap_data   = 32'h100 + k;
            tap_clk_en = alt_en ? (k % 2 == 0) : 1'b1;
            hit_now    = 0;
            if (tap_clk_en) begin
                hist.push_back({fl, tap_data});
                if (hist.size() > DEPTH) begin
                    void'(hist.pop_front());
                    if (!in_post) movf = 1;
                end
                if (in_post) begin
                    left--;
                    if (left == 0) fin = 1;
                end else if (((fl ^ val) & mask) == 4'b0000) begin
                    in_post = 1;
                    hit_now = 1;
                    left    = post;
                    if (post == 0) fin = 1;
                end
            end
            tick();
            k++;
            if (hit_now && !fin) check("hit_to_post", state, 2);
            if (abort_in_post && in_post && !fin) begin
                tap_clk_en = 1'b0;
                arm = 1'b0;
                tick();
                check("abort_state", state, 0);
                check("abort_rd_valid", rd_if.rd_valid, 0);
                hist.delete();
                return;
            end
        end
        tap_clk_en = 1'b0;
        check("capture_finished", fin, 1);
        check("done_state", state, 3);
        check("triggered", triggered, 1);
        check("overflow", overflow, movf);
        foreach (hist[i]) exp_q.push_back(hist[i]);
    endtask

    // Drains the DUT against the scoreboard, optionally stalling first.
    task automatic drain(input int stall_cycles);
        int          budget = 0;
        logic [35:0] front;
        arm = 1'b0;
        if (stall_cycles > 0 && exp_q.size() > 0) begin
            rd_if.rd_ready = 1'b0;
            front = exp_q[0];
            repeat (stall_cycles) begin
                check("stall_valid", rd_if.rd_valid, 1);
                check("stall_data", rd_if.rd_data, front);
                tick();
            end
        end
        rd_if.rd_ready = 1'b1;
        while (budget < 100 && rd_if.rd_valid) begin
            if (exp_q.size() == 0) begin
                check("extra_entry", 1, 0);
                break;
            end
            check("rd_data", rd_if.rd_data, exp_q.pop_front());
            tick();
            budget++;
        end
        rd_if.rd_ready = 1'b0;
        check("entries_left", exp_q.size(), 0);
        check("idle_after_drain", state, 0);
        check("rd_valid_idle", rd_if.rd_valid, 0);
        exp_q.delete();
    endtask

    initial begin
        reset          = 1'b1;
        arm            = 1'b0;
        tap_flags      = 4'h0;
        tap_data       = 32'h0;
        tap_clk_en     = 1'b0;
        trig_mask      = 4'h0;
        trig_value     = 4'h0;
        post_count     = 4'h0;
        rd_if.rd_ready = 1'b0;
        tick();
        tick();
        check("rst_state", state, 0);
        check("rst_rd_valid", rd_if.rd_valid, 0);
        check("rst_rd_data", rd_if.rd_data, 0);
        check("rst_triggered", triggered, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;
        tick();

        run_capture(4'b0000, 4'b0000, 0, 3, 0, 0);
        drain(0);
        check("triggered_holds", triggered, 1);

        run_capture(4'b0001, 4'b0001, 20, 5, 0, 0);
        drain(5);
        check("overflow_holds", overflow, 1);

        run_capture(4'b0001, 4'b0001, 6, 3, 1, 0);
        drain(0);

        run_capture(4'b0000, 4'b0000, 0, 15, 0, 0);
        drain(0);

        run_capture(4'b0000, 4'b0000, 0, 0, 0, 0);
        drain(2);

        run_capture(4'b0000, 4'b0000, 0, 5, 0, 1);

        run_capture(4'b0000, 4'b0000, 0, 6, 0, 0);
        check("pre_reset_valid", rd_if.rd_valid, 1);
        arm   = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_done_state", state, 0);
        check("reset_done_valid", rd_if.rd_valid, 0);
        check("reset_done_data", rd_if.rd_data, 0);
        check("reset_done_trig", triggered, 0);
        check("reset_done_ovf", overflow, 0);
        exp_q.delete();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
